data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
- Memory-side responder for the pipelined processor's data port. The processor drives Daddress, Dout and W; this block returns DataIn.
- Adds a request/ready handshake with a parameterised number of wait states so the pipeline can be tested against slow memory.
- Sits outside the processor at top level and owns a word-addressed 20-bit storage array.

Parameters:
- DATA_WIDTH, 20, word width; must match the processor data bus.
- ADDR_BITS, 8, number of address bits used to index storage; depth is 2^ADDR_BITS words.
- WAIT_STATES, 2, extra cycles before each access completes; legal range 0..15.

Ports:
- Clock  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  1  access request; sampled only when the block is accepting.
- Daddress  input  20  word address from the processor.
- Dout  input  20  write data from the processor.
- W  input  1  1 = write, 0 = read; sampled with Req.
- DataIn  output  20  read data returned to the processor.
- Ready  output  1  one-cycle completion strobe.
- Busy  output  1  high while an access is in flight and Req is being ignored.

Behaviour:
- State machine states: IDLE, WAIT, RESP. Ready = (state == RESP). Busy = (state == WAIT).
- Reset low, at any time including mid-access:
  - state goes to IDLE, DataIn = 0, Ready = 0, Busy = 0, wait counter = 0, captured request registers = 0.
  - Storage contents are not cleared.
  - Any in-flight write is dropped; the array is not modified.
- Accepting: in IDLE or RESP, on a rising edge with Req = 1:
  - Capture Daddress[ADDR_BITS-1:0], Dout and W.
  - If WAIT_STATES = 0, go to RESP. Otherwise go to WAIT with counter = WAIT_STATES - 1.
- Not accepting: in WAIT, Req is ignored; there is no queueing.
- WAIT: each edge decrements the counter. On the edge where the counter is 0, go to RESP and complete the access on that same edge:
  - Write: array[addr] <= captured data. DataIn is unchanged.
  - Read: DataIn <= array[addr].
- Latency: Ready is high in the clock cycle that begins WAIT_STATES + 1 edges after the accepting edge.
- RESP lasts exactly one cycle:
  - Req = 1: accept the new access (back-to-back).
  - Req = 0: go to IDLE.
- DataIn holds its value until the next read completes.
- Address bits above ADDR_BITS are ignored; addresses wrap modulo 2^ADDR_BITS.
- Read after write to the same address: the read returns the new data, since the write completes before the read is accepted.
- Req held continuously: one access completes every WAIT_STATES + 1 cycles.

Optional Feature:
- Macro: DATA_MEMORY_RANGE_CHECK_EN.
- Defined:
  - Extra output port Err (1 bit), reset 0.
  - On accept, the block checks Daddress[19:ADDR_BITS]. If any bit is nonzero, Err = 1 in the RESP cycle of that access.
  - For such a write, the array is not modified.
  - For such a read, DataIn = 20'hFFFFF.
  - Err is 0 in all other cycles.
- Not defined: no Err port; upper address bits are silently ignored and wrap as described above.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default (20).
  - State encoding constants: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Out-of-range read fill value 20'hFFFFF.
- One sub-module is natural: data_memory_array. It is a synchronous single-port array with inputs clock, we, addr, wdata and registered output rdata. The FSM and counter stay in the parent.

Test Plan:
- Reset and single-write timing (WAIT_STATES = 2):
  - Stimulus: Reset low for 3 cycles, then release. Req = 1, W = 1, Daddress = 5, Dout = 20'h12345 for one cycle.
  - Response: Busy is high for 2 cycles; Ready pulses once in the 3rd cycle after the accepting edge; DataIn stays 0.
- Read-back: read Daddress = 5 -> Ready after 3 cycles, DataIn = 20'h12345, held after Ready drops.
- Back-to-back reads with Req held high, addresses 5 then 6 (6 previously written with 20'h00ABC):
  - Ready pulses every 3 cycles.
  - DataIn = 20'h12345, then 20'h00ABC.
  - Req seen during Busy causes no extra access.
- WAIT_STATES = 0 with address wrap:
  - Write 20'h0000F to 20'h00105; read 20'h00005.
  - Ready is high in the cycle after each accept; the read returns 20'h0000F.
- Reset mid-access: start a write of 20'h55555 to address 9, pull Reset low while Busy = 1, release, read address 9.
  - Outputs return to 0 immediately on reset.
  - The read returns the old content, not 20'h55555.
- DATA_MEMORY_RANGE_CHECK_EN defined: read Daddress = 20'h10003 -> Err = 1 together with Ready, DataIn = 20'hFFFFF. A following write to the same address leaves array[3] unchanged.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data memory responder and its storage array.
package data_memory_responder_pkg;

    localparam int DATA_WIDTH_DEF = 20;
    localparam int DADDR_WIDTH    = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [19:0] OOR_FILL = 20'hFFFFF;

endpackage

// File: rtl/data_memory_array.sv
// Synchronous single-port word array with a registered read port (read-first).
module data_memory_array
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage write and registered read; contents are deliberately never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the processor data port with configurable wait states.
// Optional address range checking (Err output) is enabled by DATA_MEMORY_RANGE_CHECK_EN.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Req,
    input  logic [DADDR_WIDTH-1:0] Daddress,
    input  logic [DATA_WIDTH-1:0]  Dout,
    input  logic                   W,
    output logic [DATA_WIDTH-1:0]  DataIn,
    output logic                   Ready,
    output logic                   Busy
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    ,
    output logic                   Err
`endif
);

    localparam logic       NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                 state_r, state_next_s;
    logic [3:0]             cnt_r, cnt_next_s;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic                   wr_r;
    logic                   ready_r, busy_r, err_r;
    logic                   ready_next_s, busy_next_s, err_next_s;
    logic                   rd_fresh_r;
    logic [DATA_WIDTH-1:0]  data_hold_r;

    logic                   accept_s, complete_s, we_s, rd_done_s;
    logic [ADDR_BITS-1:0]   acc_addr_s;
    logic [DATA_WIDTH-1:0]  acc_data_s;
    logic                   acc_wr_s, acc_oor_s, oor_live_s;
    logic [DATA_WIDTH-1:0]  rdata_s;

`ifdef DATA_MEMORY_RANGE_CHECK_EN
    logic oor_r;
    assign oor_live_s = |Daddress[DADDR_WIDTH-1:ADDR_BITS];
`else
    logic unused_upper_s;
    assign unused_upper_s = ^Daddress[DADDR_WIDTH-1:ADDR_BITS];
    assign oor_live_s     = 1'b0;
`endif

    assign accept_s   = Req && ((state_r == IDLE) || (state_r == RESP));
    assign complete_s = ((state_r == WAIT) && (cnt_r == 4'd0)) || (accept_s && NO_WAIT);

    // Completing access comes from the captured registers in WAIT, or straight off the bus with no wait states.
    always_comb begin
        if (state_r == WAIT) begin
            acc_addr_s = addr_r;
            acc_data_s = wdata_r;
            acc_wr_s   = wr_r;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
            acc_oor_s  = oor_r;
`else
            acc_oor_s  = 1'b0;
`endif
        end else begin
            acc_addr_s = Daddress[ADDR_BITS-1:0];
            acc_data_s = Dout;
            acc_wr_s   = W;
            acc_oor_s  = oor_live_s;
        end
    end

    // Reset gating keeps a write from landing while the block is being reset.
    assign we_s      = complete_s && acc_wr_s && !acc_oor_s && Reset;
    assign rd_done_s = complete_s && !acc_wr_s;

    data_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .clock (Clock),
        .we    (we_s),
        .addr  (acc_addr_s),
        .wdata (acc_data_s),
        .rdata (rdata_s)
    );

    // State and wait counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: accept in IDLE/RESP, count down in WAIT.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE, RESP: begin
                if (Req) begin
                    if (NO_WAIT) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so the strobes come out of flops.
    always_comb begin
        ready_next_s = (state_next_s == RESP);
        busy_next_s  = (state_next_s == WAIT);
        err_next_s   = complete_s && acc_oor_s;
    end

    // Registered strobes and captured request.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            wr_r    <= 1'b0;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
            oor_r   <= 1'b0;
`endif
        end else begin
            ready_r <= ready_next_s;
            busy_r  <= busy_next_s;
            err_r   <= err_next_s;
            if (accept_s) begin
                addr_r  <= Daddress[ADDR_BITS-1:0];
                wdata_r <= Dout;
                wr_r    <= W;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
                oor_r   <= oor_live_s;
`endif
            end
        end
    end

    // Read data: the array output is shown right after a read, then frozen in data_hold_r.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_fresh_r  <= 1'b0;
            data_hold_r <= '0;
        end else if (rd_done_s) begin
            rd_fresh_r  <= !acc_oor_s;
            data_hold_r <= acc_oor_s ? DATA_WIDTH'(OOR_FILL) : (rd_fresh_r ? rdata_s : data_hold_r);
        end else if (rd_fresh_r) begin
            rd_fresh_r  <= 1'b0;
            data_hold_r <= rdata_s;
        end else begin
            rd_fresh_r  <= 1'b0;
            data_hold_r <= data_hold_r;
        end
    end

    assign DataIn = rd_fresh_r ? rdata_s : data_hold_r;
    assign Ready  = ready_r;
    assign Busy   = busy_r;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    assign Err    = err_r;
`else
    logic unused_err_s;
    assign unused_err_s = err_r;
`endif

endmodule
